utopia_rx_cell_collector: RTL

UTOPIA Level-1 receive-side port controller sitting directly upstream of the ATM router's cell-switching core, one instance per Rx port (0..3). It acts as ATM-layer master toward the PHY: it drives `Rx_en`, samples `Rx_data`/`Rx_soc` and assembles one 53-byte cell into a local buffer. It then checks the header HEC and streams the cell to the router core over a valid/ready byte interface.

---
 rtl/utopia_rx_cell_collector_if.sv | 23 ++
 rtl/utopia_rx_cell_collector.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/utopia_rx_cell_collector_if.sv
// rtl/utopia_rx_cell_collector_if.sv - UTOPIA Rx PHY signals plus the byte stream toward the router core
interface utopia_rx_cell_collector_if;
  logic       Rx_clav;
  logic       Rx_soc;
  logic [7:0] Rx_data;
  logic       Rx_en;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       out_valid;
  logic       out_ready;
  logic       out_hec_err;

  modport master (
    input  Rx_clav, Rx_soc, Rx_data, out_ready,
    output Rx_en, out_data, out_sop, out_eop, out_valid, out_hec_err
  );

  modport slave (
    output Rx_clav, Rx_soc, Rx_data, out_ready,
    input  Rx_en, out_data, out_sop, out_eop, out_valid, out_hec_err
  );
endinterface

// File: rtl/utopia_rx_cell_collector.sv
// rtl/utopia_rx_cell_collector.sv - UTOPIA L1 Rx cell collector with HEC check and single-cell drain buffer
module utopia_rx_cell_collector #(
  parameter bit DROP_BAD_HEC = 1'b1,
  parameter int CELL_BYTES   = 53
) (
  input  logic                              clk,
  input  logic                              rst,
  utopia_rx_cell_collector_if.master        bus,
  output logic [7:0]                        o_hec_err_cnt,
  output logic [7:0]                        o_runt_cnt
);

  localparam logic [5:0] LAST = 6'(CELL_BYTES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_SOC, COLLECT, CHECK, DRAIN} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_buf [CELL_BYTES];
  logic [5:0] r_byte_cnt;
  logic [5:0] r_rd_ptr;
  logic       r_rx_en;
  logic       r_hec_err;
  logic [7:0] r_hec_cnt;
  logic [7:0] r_runt_cnt;

  logic       w_capture;
  logic       w_wr_en;
  logic [5:0] w_wr_idx;
  logic       w_xfer;
  logic       w_last_out;
  logic [7:0] w_hec;
  logic       w_hec_bad;

  // HEC: CRC-8 (x^8+x^2+x+1), zero seed, header bits MSB first
  function automatic logic [7:0] crc8_hdr(input logic [31:0] hdr);
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      crc = (crc[7] ^ hdr[i]) ? ((crc << 1) ^ 8'h07) : (crc << 1);
    end
    return crc;
  endfunction

  assign w_hec      = crc8_hdr({r_buf[0], r_buf[1], r_buf[2], r_buf[3]}) ^ 8'h55;
  assign w_hec_bad  = (w_hec != r_buf[4]);
  assign w_capture  = !r_rx_en;
  assign w_last_out = (r_rd_ptr == LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_en       = 1'b0;
    w_wr_idx      = r_byte_cnt;
    w_xfer        = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    bus.out_sop   = 1'b0;
    bus.out_eop   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.Rx_clav) w_state_nxt = WAIT_SOC;
      end
      WAIT_SOC: begin
        if (w_capture && bus.Rx_soc) begin
          w_wr_en     = 1'b1;
          w_wr_idx    = 6'd0;
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        // An early start-of-cell restarts the cell rather than completing it
        if (w_capture) begin
          w_wr_en = 1'b1;
          if (bus.Rx_soc)              w_wr_idx    = 6'd0;
          else if (r_byte_cnt == LAST) w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        w_state_nxt = (w_hec_bad && DROP_BAD_HEC) ? IDLE : DRAIN;
      end
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_buf[r_rd_ptr];
        bus.out_sop   = (r_rd_ptr == 6'd0);
        bus.out_eop   = w_last_out;
        w_xfer        = bus.out_ready;
        if (w_xfer && w_last_out) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_en    <= 1'b1;
      r_byte_cnt <= 6'd0;
      r_rd_ptr   <= 6'd0;
      r_hec_err  <= 1'b0;
      r_hec_cnt  <= 8'h00;
      r_runt_cnt <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Rx_clav) r_rx_en <= 1'b0;
        end
        WAIT_SOC: begin
          if (w_capture && bus.Rx_soc) r_byte_cnt <= 6'd1;
        end
        COLLECT: begin
          if (w_capture) begin
            if (bus.Rx_soc) begin
              r_byte_cnt <= 6'd1;
              if (r_runt_cnt != 8'hFF) r_runt_cnt <= r_runt_cnt + 8'd1;
            end else if (r_byte_cnt == LAST) begin
              // Buffer is full: stall the PHY until the cell has drained
              r_rx_en    <= 1'b1;
              r_byte_cnt <= 6'd0;
            end else begin
              r_byte_cnt <= r_byte_cnt + 6'd1;
            end
          end
        end
        CHECK: begin
          if (w_hec_bad && r_hec_cnt != 8'hFF) r_hec_cnt <= r_hec_cnt + 8'd1;
          r_rd_ptr  <= 6'd0;
          r_hec_err <= w_hec_bad && !DROP_BAD_HEC;
        end
        DRAIN: begin
          if (w_xfer) begin
            if (w_last_out) begin
              r_rd_ptr  <= 6'd0;
              r_hec_err <= 1'b0;
            end else begin
              r_rd_ptr <= r_rd_ptr + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) r_buf[w_wr_idx] <= bus.Rx_data;
  end

  assign bus.Rx_en       = r_rx_en;
  assign bus.out_hec_err = r_hec_err;
  assign o_hec_err_cnt   = r_hec_cnt;
  assign o_runt_cnt      = r_runt_cnt;

endmodule
